uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser_pkg.sv | 31 +++
 rtl/uart_frame_parser_idle_timer.sv | 30 +++
 rtl/uart_frame_parser.sv | 119 +++++++++++
 tb/tb_uart_frame_parser.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command-frame parser: state codes,
// frame field positions and the frame checksum.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPC  = 3'd1,
    S_ARGH = 3'd2,
    S_ARGL = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

  localparam int FLD_SYNC  = 0;
  localparam int FLD_OPC   = 1;
  localparam int FLD_ARGH  = 2;
  localparam int FLD_ARGL  = 3;
  localparam int FLD_CHK   = 4;
  localparam int FRAME_LEN = 5;

  function automatic logic [7:0] frame_chk(
    input logic [7:0] opc,
    input logic [7:0] argh,
    input logic [7:0] argl
  );
    return opc ^ argh ^ argl;
  endfunction

endpackage

// File: rtl/uart_frame_parser_idle_timer.sv
// Inter-byte idle timer for the frame parser; only built with
// PARSER_TIMEOUT_EN. Counts while run is high and no byte arrives.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 520830,
  parameter int TO_BITS        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

  logic [TO_BITS-1:0] cnt;

  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Pops bytes from an RX FIFO and decodes SYNC/OPC/ARGH/ARGL/CHK frames.
// Define PARSER_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 520830,
  parameter int         TO_BITS        = 20
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        rx_empty,
  input  logic [7:0]  read_data,
  output logic        read_uart,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_arg,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  state_t     state, state_nxt;
  logic       popped_q;
  logic       pop;
  logic       timeout;
  logic       err_evt;
  logic [7:0] opc_q, argh_q, argl_q;
  logic [7:0] err_q;
  logic       frame_err_q;

  // Gated by reset_n so no byte is lost while the FSM is held in reset.
  assign pop = reset_n && !rx_empty && !popped_q
               && (state != S_HOLD);

  assign read_uart  = pop;
  assign cmd_valid  = (state == S_HOLD);
  assign cmd_opcode = opc_q;
  assign cmd_arg    = {argh_q, argl_q};
  assign frame_err  = frame_err_q;
  assign err_count  = err_q;

`ifdef PARSER_TIMEOUT_EN
  logic run;

  assign run = (state == S_OPC) || (state == S_ARGH)
               || (state == S_ARGL) || (state == S_CHK);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_BITS       (TO_BITS)
  ) u_timer (
    .clk   (clk_50MHz),
    .rst_n (reset_n),
    .run   (run),
    .clear (pop),
    .expire(timeout)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ^{TIMEOUT_CYCLES[0], TO_BITS[0]};
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    unique case (state)
      S_IDLE:
        if (pop && read_data == SYNC_BYTE) state_nxt = S_OPC;
      S_OPC:  if (pop) state_nxt = S_ARGH;
      S_ARGH: if (pop) state_nxt = S_ARGL;
      S_ARGL: if (pop) state_nxt = S_CHK;
      S_CHK:
        if (pop) begin
          if (read_data == frame_chk(opc_q, argh_q, argl_q)) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_IDLE;
            err_evt   = 1'b1;
          end
        end
      S_HOLD: if (cmd_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A byte arriving in the expiry cycle keeps the frame alive.
    if (!pop && timeout) begin
      state_nxt = S_IDLE;
      err_evt   = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      popped_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
      opc_q       <= '0;
      argh_q      <= '0;
      argl_q      <= '0;
    end else begin
      state       <= state_nxt;
      popped_q    <= pop;
      frame_err_q <= err_evt;
      if (err_evt && err_q != 8'hFF) err_q <= err_q + 1'b1;
      if (pop) begin
        unique case (1'b1)
          state == S_OPC:  opc_q  <= read_data;
          state == S_ARGH: argh_q <= read_data;
          state == S_ARGL: argl_q <= read_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a byte-FIFO model.
// Build with PARSER_TIMEOUT_EN to exercise the idle timeout.
module tb_uart_frame_parser;

`ifdef PARSER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 520830;
`endif

  logic        clk;
  logic        reset_n;
  logic        rx_empty;
  logic [7:0]  read_data;
  logic        read_uart;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_arg;
  logic        frame_err;
  logic [7:0]  err_count;

  uart_frame_parser #(
    .SYNC_BYTE     (8'hAA),
    .TIMEOUT_CYCLES(TO),
    .TO_BITS       (20)
  ) dut (
    .clk_50MHz (clk),
    .reset_n   (reset_n),
    .rx_empty  (rx_empty),
    .read_data (read_data),
    .read_uart (read_uart),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_arg   (cmd_arg),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  fifo[$];
  logic [7:0]  got_opc[$];
  logic [15:0] got_arg[$];
  int nvec  = 0;
  int nfail = 0;
  int pops  = 0;
  int errs  = 0;
  logic pend;

  task automatic sync_fifo();
    rx_empty  = (fifo.size() == 0);
    read_data = rx_empty ? 8'h00 : fifo[0];
  endtask

  always begin
    @(negedge clk);
    pend = read_uart;
    @(posedge clk);
    #1;
    if (pend && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
      sync_fifo();
    end
  end

  always @(negedge clk) begin
    if (frame_err) errs++;
    if (cmd_valid && cmd_ready) begin
      got_opc.push_back(cmd_opcode);
      got_arg.push_back(cmd_arg);
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input logic [63:0] b, input int n);
    @(posedge clk);
    #2;
    for (int i = 0; i < n; i++) fifo.push_back(b[63-8*i -: 8]);
    sync_fifo();
  endtask

  task automatic clear_obs();
    pops = 0;
    errs = 0;
    got_opc.delete();
    got_arg.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((fifo.size() != 0 || cmd_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    if (c >= budget) check({name, "_drain_timeout"}, 1, 0);
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          n;
    int          cmds;
    logic [7:0]  opc;
    logic [15:0] arg;
    int          errs;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"basic",  64'hAA10123436_000000, 5, 1, 8'h10, 16'h1234, 0, 8'd0};
    tbl[1] = '{"resync", 64'h5500AA01000203_00, 7, 1, 8'h01, 16'h0002, 0, 8'd0};
    tbl[2] = '{"badchk", 64'hAA10123400_000000, 5, 0, 8'h00, 16'h0000, 1, 8'd1};
    tbl[3] = '{"syncdat",64'hAAAAAAAAAA_000000, 5, 1, 8'hAA, 16'hAAAA, 0, 8'd1};
    tbl[4] = '{"ffzero", 64'hAAFF00FF00_000000, 5, 1, 8'hFF, 16'h00FF, 0, 8'd1};
    tbl[5] = '{"badchk2",64'hAA01020305_000000, 5, 0, 8'h00, 16'h0000, 1, 8'd2};

    reset_n   = 1'b0;
    cmd_ready = 1'b0;
    sync_fifo();
    #22;
    check("rst_read_uart", read_uart, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_opcode", cmd_opcode, 0);
    check("rst_arg", cmd_arg, 0);
    check("rst_err_count", err_count, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_obs();
      cmd_ready = 1'b1;
      push_bytes(tbl[v].bytes, tbl[v].n);
      drain(tbl[v].name, 200);
      check({tbl[v].name, "_cmds"}, got_opc.size(), tbl[v].cmds);
      if (got_opc.size() > 0) begin
        check({tbl[v].name, "_opc"}, got_opc[0], tbl[v].opc);
        check({tbl[v].name, "_arg"}, got_arg[0], tbl[v].arg);
      end
      check({tbl[v].name, "_errs"}, errs, tbl[v].errs);
      check({tbl[v].name, "_pops"}, pops, tbl[v].n);
      check({tbl[v].name, "_err_count"}, err_count, tbl[v].ecnt);
    end

    // Back-pressure: first command held, second frame waits in FIFO.
    begin
      int c;
      int unstable;
      logic [7:0]  o0;
      logic [15:0] a0;
      clear_obs();
      @(posedge clk);
      #2 cmd_ready = 1'b0;
      push_bytes(64'hAA10123436_000000, 5);
      push_bytes(64'hAA20000525_000000, 5);
      c = 0;
      while (!cmd_valid && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("hold_valid_seen", cmd_valid, 1);
      o0 = cmd_opcode;
      a0 = cmd_arg;
      unstable = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!cmd_valid || cmd_opcode != o0 || cmd_arg != a0 || read_uart)
          unstable++;
      end
      check("hold_unstable", unstable, 0);
      check("hold_opc", o0, 8'h10);
      check("hold_arg", a0, 16'h1234);
      check("hold_pops", pops, 5);
      check("hold_fifo_left", fifo.size(), 5);
      @(posedge clk);
      #2 cmd_ready = 1'b1;
      drain("hold", 200);
      check("hold_cmds", got_opc.size(), 2);
      if (got_opc.size() == 2) begin
        check("hold_opc2", got_opc[1], 8'h20);
        check("hold_arg2", got_arg[1], 16'h0005);
      end
      check("hold_pops_total", pops, 10);
    end

    // Stalled frame after AA 10.
    clear_obs();
    push_bytes(64'hAA10_000000000000, 2);
    repeat (90) @(negedge clk);
    check("stall_early_err", errs, 0);
    repeat (60) @(negedge clk);
`ifdef PARSER_TIMEOUT_EN
    check("stall_timeout_err", errs, 1);
    check("stall_state_idle", cmd_valid, 0);
    push_bytes(64'hAA10123436_000000, 5);
`else
    check("stall_no_err", errs, 0);
    check("stall_no_cmd", cmd_valid, 0);
    push_bytes(64'h123436_0000000000, 3);
`endif
    drain("stall", 300);
    check("stall_cmds", got_opc.size(), 1);
    if (got_opc.size() > 0) begin
      check("stall_opc", got_opc[0], 8'h10);
      check("stall_arg", got_arg[0], 16'h1234);
    end

    // Reset mid-frame.
    push_bytes(64'hAA1012_0000000000, 3);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    clear_obs();
    #1;
    check("mid_rst_read_uart", read_uart, 0);
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_opcode", cmd_opcode, 0);
    check("mid_rst_arg", cmd_arg, 0);
    check("mid_rst_err_count", err_count, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    push_bytes(64'hAA03040502_000000, 5);
    drain("post_rst", 200);
    check("post_rst_cmds", got_opc.size(), 1);
    if (got_opc.size() > 0) begin
      check("post_rst_opc", got_opc[0], 8'h03);
      check("post_rst_arg", got_arg[0], 16'h0405);
    end
    check("post_rst_errs", errs, 0);

    // Error counter saturation.
    clear_obs();
    for (int k = 0; k < 260; k++) push_bytes(64'hAA00000001_000000, 5);
    drain("sat", 8000);
    check("sat_errs", errs, 260);
    check("sat_err_count", err_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
